// File: rtl/mcycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// opcode/funct constants, ALU encodings, control bundle and decode helpers.
package mcycle_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_EX_R    = 5'd2,
    S_EX_I    = 5'd3,
    S_EX_ADDR = 5'd4,
    S_MEM_RD  = 5'd5,
    S_MEM_WR  = 5'd6,
    S_WB_R    = 5'd7,
    S_WB_I    = 5'd8,
    S_WB_LW   = 5'd9,
    S_EX_BR   = 5'd10,
    S_EX_J    = 5'd11,
    S_EX_JAL  = 5'd12,
    S_EX_JR   = 5'd13,
    S_PC_JR   = 5'd14,
    S_EX_LUI  = 5'd15
  } state_e;

  // Opcodes (Inst[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // R-type funct (Inst[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  // How a state chooses its ALU operation
  typedef enum logic [2:0] {
    AC_NONE  = 3'd0,
    AC_ADD   = 3'd1,
    AC_SUB   = 3'd2,
    AC_OR    = 3'd3,
    AC_FUNCT = 3'd4,
    AC_IMM   = 3'd5
  } alu_cls_e;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       RegWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       Beq;
    logic       data2Mem;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
  } ctrl_t;

  // Dispatch from ID; unknown encodings fall back to fetch (NOP)
  function automatic state_e id_dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_e s;
    s = S_IF;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
          FN_NOR, FN_SLT, FN_SLL, FN_SRL: s = S_EX_R;
          FN_JR:                          s = S_EX_JR;
          default:                        s = S_IF;
        endcase
      end
      OP_LW, OP_SW:                     s = S_EX_ADDR;
      OP_BEQ, OP_BNE:                   s = S_EX_BR;
      OP_J:                             s = S_EX_J;
      OP_JAL:                           s = S_EX_JAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: s = S_EX_I;
      OP_LUI:                           s = S_EX_LUI;
      default:                          s = S_IF;
    endcase
    return s;
  endfunction

  function automatic alu_cls_e alu_class(input state_e s);
    alu_cls_e c;
    case (s)
      S_IF, S_ID, S_EX_ADDR: c = AC_ADD;
      S_EX_BR:               c = AC_SUB;
      S_EX_JR:               c = AC_OR;
      S_EX_R:                c = AC_FUNCT;
      S_EX_I:                c = AC_IMM;
      default:               c = AC_NONE;
    endcase
    return c;
  endfunction

  // Moore control decode; ovf suppresses the R/I writeback
  function automatic ctrl_t ctrl_decode(input state_e s, input logic [5:0] op, input logic ovf);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.IorD = 1'b1; c.MemRead = 1'b1; c.IRWrite = 1'b1;
        c.ALUSrcA = 2'b01; c.ALUSrcB = 2'b01; c.PCWrite = 1'b1;
      end
      S_ID: begin
        c.ALUSrcA = 2'b01; c.ALUSrcB = 2'b11;
      end
      S_EX_I, S_EX_ADDR: c.ALUSrcB = 2'b10;
      S_MEM_RD: c.MemRead  = 1'b1;
      S_MEM_WR: c.MemWrite = 1'b1;
      S_WB_R: begin
        c.RegDst = 2'b01; c.RegWrite = ~ovf;
      end
      S_WB_I:  c.RegWrite = ~ovf;
      S_WB_LW: begin
        c.MemtoReg = 2'b01; c.RegWrite = 1'b1;
      end
      S_EX_BR: begin
        c.PCWriteCond = 1'b1; c.PCSource = 2'b01; c.Beq = (op == OP_BEQ);
      end
      S_EX_J: begin
        c.PCWrite = 1'b1; c.PCSource = 2'b10;
      end
      S_EX_JAL: begin
        c.PCWrite = 1'b1; c.PCSource = 2'b10;
        c.RegDst = 2'b10; c.MemtoReg = 2'b11; c.RegWrite = 1'b1;
      end
      S_PC_JR: begin
        c.PCWrite = 1'b1; c.PCSource = 2'b11;
      end
      S_EX_LUI: begin
        c.MemtoReg = 2'b10; c.RegWrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcycle_alu_dec.sv
// ALU operation decode from state class, opcode and funct.
module mcycle_alu_dec
  import mcycle_ctrl_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op
);

  // Fixed ops for address/branch/jr states, funct or opcode lookup for EX
  always_comb begin
    alu_op = ALU_AND;
    case (cls)
      AC_ADD: alu_op = ALU_ADD;
      AC_SUB: alu_op = ALU_SUB;
      AC_OR:  alu_op = ALU_OR;
      AC_FUNCT: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          default: alu_op = ALU_AND;
        endcase
      end
      AC_IMM: begin
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control FSM. Outputs are registered from the next-state
// decode, so they always equal the Moore decode of state_out.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Beq,
  output logic        data2Mem,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [3:0]  ALU_operation,
  output logic [4:0]  state_out
);

  state_e     state, nxt;
  logic       ovf_q, ovf_nxt;
  ctrl_t      ctrl_q;
  logic [3:0] alu_q, alu_nxt;
  logic [5:0] op, fn;

  assign op = Inst_in[31:26];
  assign fn = Inst_in[5:0];

  // Register fields and the zero flag are consumed by the data path only
  logic unused_inputs;
  assign unused_inputs = ^{Inst_in[25:6], zero};

  // Next-state selection
  always_comb begin
    nxt = state;
    case (state)
      S_IF:      if (MIO_ready) nxt = S_ID;
      S_ID:      nxt = id_dispatch(op, fn);
      S_EX_R:    nxt = S_WB_R;
      S_EX_I:    nxt = S_WB_I;
      S_EX_ADDR: nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (MIO_ready) nxt = S_WB_LW;
      S_MEM_WR:  if (MIO_ready) nxt = S_IF;
      S_EX_JR:   nxt = S_PC_JR;
      default:   nxt = S_IF;
    endcase
  end

  // Overflow flag: sampled at the end of add/sub/addi execute, cleared in fetch
  always_comb begin
    ovf_nxt = ovf_q;
    if (state == S_IF)
      ovf_nxt = 1'b0;
    else if (state == S_EX_R && (fn == FN_ADD || fn == FN_SUB))
      ovf_nxt = overflow;
    else if (state == S_EX_I && op == OP_ADDI)
      ovf_nxt = overflow;
  end

  mcycle_alu_dec u_alu_dec (
    .cls    (alu_class(nxt)),
    .opcode (op),
    .funct  (fn),
    .alu_op (alu_nxt)
  );

  // State, flag and registered control outputs; reset forces the fetch decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IF;
      ovf_q  <= 1'b0;
      ctrl_q <= ctrl_decode(S_IF, 6'd0, 1'b0);
      alu_q  <= ALU_ADD;
    end else begin
      state  <= nxt;
      ovf_q  <= ovf_nxt;
      ctrl_q <= ctrl_decode(nxt, op, ovf_nxt);
      alu_q  <= alu_nxt;
    end
  end

  assign MemRead       = ctrl_q.MemRead;
  assign MemWrite      = ctrl_q.MemWrite;
  assign IorD          = ctrl_q.IorD;
  assign IRWrite       = ctrl_q.IRWrite;
  assign RegWrite      = ctrl_q.RegWrite;
  assign PCWrite       = ctrl_q.PCWrite;
  assign PCWriteCond   = ctrl_q.PCWriteCond;
  assign Beq           = ctrl_q.Beq;
  assign data2Mem      = ctrl_q.data2Mem;
  assign RegDst        = ctrl_q.RegDst;
  assign MemtoReg      = ctrl_q.MemtoReg;
  assign ALUSrcA       = ctrl_q.ALUSrcA;
  assign ALUSrcB       = ctrl_q.ALUSrcB;
  assign PCSource      = ctrl_q.PCSource;
  assign ALU_operation = alu_q;
  assign state_out     = state;

endmodule
